// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg : shared UART constants, receiver FSM encoding and divider helper
// Rev 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } uart_state_t;

  // Rounded clocks per oversample tick, never below one.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int den;
    int d;
    den = baud * os;
    d   = (clk_hz + den / 2) / den;
    return (d < 1) ? 1 : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_baud_tick : one-clock oversample tick every DIV system clocks
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // With DIV = 1 the counter sits at zero and the tick is permanently high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)             cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_os : oversampling UART receiver, majority vote, valid/ready output
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 break_det
);

  localparam int HALF = OVERSAMPLE / 2;
  localparam int TW   = $clog2(OVERSAMPLE);
  localparam int BW   = $clog2(DATA_BITS);

  localparam logic [TW-1:0] T_S0   = TW'(HALF - 1);
  localparam logic [TW-1:0] T_S1   = TW'(HALF);
  localparam logic [TW-1:0] T_DEC  = TW'(HALF + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          S_LAST = 1'(STOP_BITS - 1);

  logic [1:0]           sync;
  logic                 rx_s;
  logic                 tick;
  uart_state_t          state, state_nxt;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bitcnt;
  logic                 stopcnt;
  logic [1:0]           samp;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 par_err_r;
  logic                 stop1_bit;
  logic                 frame_r;
  logic                 armed;

  logic at_s0, at_s1, at_dec, at_end, maj, exp_par, brk, accept, load, drop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], UART_RX};
  end
  assign rx_s = sync[1];

  uart_baud_tick #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  assign at_s0   = tick && (tcnt == T_S0);
  assign at_s1   = tick && (tcnt == T_S1);
  assign at_dec  = tick && (tcnt == T_DEC);
  assign at_end  = tick && (tcnt == T_LAST);
  // Third vote is the live sample taken at the decision tick itself.
  assign maj     = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
  assign exp_par = (PARITY == PAR_ODD) ? ~^shreg : ^shreg;
  assign brk     = (shreg == '0) && !par_bit && !stop1_bit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (tick && !rx_s && armed) state_nxt = ST_START;
      ST_START: begin
        if (at_dec && maj) state_nxt = ST_IDLE;
        else if (at_end)   state_nxt = ST_DATA;
      end
      ST_DATA:   if (at_end && bitcnt == B_LAST)
                   state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (at_end) state_nxt = ST_STOP;
      // Leave at the last stop decision so a following start bit is not missed.
      ST_STOP:   if (at_dec && stopcnt == S_LAST) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcnt      <= '0;
      bitcnt    <= '0;
      stopcnt   <= 1'b0;
      samp      <= 2'b11;
      shreg     <= '0;
      par_bit   <= 1'b0;
      par_err_r <= 1'b0;
      stop1_bit <= 1'b1;
      frame_r   <= 1'b0;
      armed     <= 1'b0;
    end else begin
      if (state == ST_IDLE)  tcnt <= '0;
      else if (tick)         tcnt <= (tcnt == T_LAST) ? '0 : tcnt + 1'b1;

      if (at_s0) samp[0] <= rx_s;
      if (at_s1) samp[1] <= rx_s;

      // A held-low line must go high before another start bit is accepted.
      if (state == ST_DONE) armed <= 1'b0;
      else if (rx_s)        armed <= 1'b1;

      case (state)
        ST_START: begin
          bitcnt    <= '0;
          stopcnt   <= 1'b0;
          par_bit   <= 1'b0;
          par_err_r <= 1'b0;
          frame_r   <= 1'b0;
          stop1_bit <= 1'b1;
        end
        ST_DATA: begin
          if (at_dec) shreg  <= {maj, shreg[DATA_BITS-1:1]};
          if (at_end) bitcnt <= bitcnt + 1'b1;
        end
        ST_PARITY: begin
          if (at_dec) begin
            par_bit   <= maj;
            par_err_r <= maj ^ exp_par;
          end
        end
        ST_STOP: begin
          if (at_dec) begin
            if (!maj)     frame_r   <= 1'b1;
            if (!stopcnt) stop1_bit <= maj;
          end
          if (at_end) stopcnt <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign accept = valid && ready;
  assign load   = (state == ST_DONE) && (!valid || ready);
  assign drop   = (state == ST_DONE) && valid && !ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      break_det <= (state == ST_DONE) && brk;
      if (load) begin
        data       <= shreg;
        frame_err  <= frame_r;
        parity_err <= par_err_r;
        valid      <= 1'b1;
      end else if (accept) begin
        valid      <= 1'b0;
      end
      if (drop)        overrun <= 1'b1;
      else if (accept) overrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_rx_os : directed self-checking bench for uart_rx_os (8N1, 8E1, 8N2)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_rx_os;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line = 1'b1;
  logic ready = 1'b1;
  int   sel = 0;
  int   cyc = 0;

  logic       rx_a, rx_b, rx_c;
  logic [7:0] d_a, d_b, d_c;
  logic       v_a, v_b, v_c, fe_a, fe_b, fe_c, pe_a, pe_b, pe_c;
  logic       ov_a, ov_b, ov_c, bk_a, bk_b, bk_c;

  logic [7:0] obs_data;
  logic       obs_valid, obs_fe, obs_pe, obs_ovr, obs_brk;

  typedef struct packed {
    int         cyc;
    logic       pe;
    logic       fe;
    logic [7:0] d;
  } word_t;

  word_t q[$];
  int    brk_cnt = 0;
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rx_a = (sel == 0) ? line : 1'b1;
  assign rx_b = (sel == 1) ? line : 1'b1;
  assign rx_c = (sel == 2) ? line : 1'b1;

  uart_rx_os #(.CLK_HZ(1843200), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8),
               .PARITY(0), .STOP_BITS(1)) u_a (
    .clock(clk), .reset(rst), .UART_RX(rx_a), .data(d_a), .valid(v_a), .ready(ready),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a), .break_det(bk_a));

  uart_rx_os #(.CLK_HZ(1843200), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8),
               .PARITY(2), .STOP_BITS(1)) u_b (
    .clock(clk), .reset(rst), .UART_RX(rx_b), .data(d_b), .valid(v_b), .ready(ready),
    .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b), .break_det(bk_b));

  uart_rx_os #(.CLK_HZ(1843200), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8),
               .PARITY(0), .STOP_BITS(2)) u_c (
    .clock(clk), .reset(rst), .UART_RX(rx_c), .data(d_c), .valid(v_c), .ready(ready),
    .frame_err(fe_c), .parity_err(pe_c), .overrun(ov_c), .break_det(bk_c));

  always_comb begin
    obs_data = d_a; obs_valid = v_a; obs_fe = fe_a; obs_pe = pe_a; obs_ovr = ov_a; obs_brk = bk_a;
    if (sel == 1) begin
      obs_data = d_b; obs_valid = v_b; obs_fe = fe_b; obs_pe = pe_b; obs_ovr = ov_b; obs_brk = bk_b;
    end else if (sel == 2) begin
      obs_data = d_c; obs_valid = v_c; obs_fe = fe_c; obs_pe = pe_c; obs_ovr = ov_c; obs_brk = bk_c;
    end
  end

  // Accepted words and break pulses, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst && obs_valid && ready) q.push_back('{cyc: cyc, pe: obs_pe, fe: obs_fe, d: obs_data});
    if (!rst && obs_brk) brk_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit n of 'bits' goes on the line n-th, one bit time (16 clocks) each.
  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      line = bits[i];
      repeat (16) @(posedge clk);
      #1;
    end
    line = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic word_t front_word();
    if (q.size() == 0) return '{cyc: -1, pe: 1'b1, fe: 1'b1, d: 8'hFF};
    return q[0];
  endfunction

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int    t0;
    word_t w;

    idle(4);
    check_eq("rst_valid", 32'(obs_valid), 32'd0);
    check_eq("rst_data",  32'(obs_data),  32'd0);
    check_eq("rst_ovr",   32'(obs_ovr),   32'd0);
    check_eq("rst_brk",   32'(obs_brk),   32'd0);
    rst = 1'b0;
    idle(20);

    // 8N1 0xA5 with latency from the start edge
    q.delete(); brk_cnt = 0;
    t0 = cyc;
    send_bits({6'b0, 1'b1, 8'hA5, 1'b0}, 10);
    idle(16);
    w = front_word();
    check_eq("a5_count",   32'(q.size()), 32'd1);
    check_eq("a5_data",    32'(w.d),      32'hA5);
    check_eq("a5_fe",      32'(w.fe),     32'd0);
    check_eq("a5_pe",      32'(w.pe),     32'd0);
    check_eq("a5_ovr",     32'(obs_ovr),  32'd0);
    check_eq("a5_brk",     32'(brk_cnt),  32'd0);
    check_eq("a5_latency", 32'(w.cyc - t0), 32'd158);

    // 5-clock low glitch is a false start
    q.delete();
    line = 1'b0;
    idle(5);
    line = 1'b1;
    idle(40);
    check_eq("glitch_count", 32'(q.size()), 32'd0);
    check_eq("glitch_idle",  32'(u_a.state), 32'(ST_IDLE));
    send_bits({6'b0, 1'b1, 8'h3C, 1'b0}, 10);
    idle(16);
    w = front_word();
    check_eq("3c_data", 32'(w.d), 32'h3C);

    // Break: line low for two frame times
    q.delete(); brk_cnt = 0;
    line = 1'b0;
    idle(320);
    line = 1'b1;
    idle(32);
    w = front_word();
    check_eq("brk_count", 32'(q.size()), 32'd1);
    check_eq("brk_data",  32'(w.d),      32'h00);
    check_eq("brk_fe",    32'(w.fe),     32'd1);
    check_eq("brk_pulses", 32'(brk_cnt), 32'd1);
    q.delete();
    send_bits({6'b0, 1'b1, 8'h55, 1'b0}, 10);
    idle(16);
    w = front_word();
    check_eq("after_brk_data", 32'(w.d), 32'h55);
    check_eq("after_brk_fe",   32'(w.fe), 32'd0);

    // Overrun with ready low
    q.delete();
    ready = 1'b0;
    send_bits({6'b0, 1'b1, 8'h11, 1'b0}, 10);
    idle(16);
    send_bits({6'b0, 1'b1, 8'h22, 1'b0}, 10);
    idle(16);
    check_eq("ovr_valid", 32'(obs_valid), 32'd1);
    check_eq("ovr_data",  32'(obs_data),  32'h11);
    check_eq("ovr_flag",  32'(obs_ovr),   32'd1);
    ready = 1'b1;
    idle(1);
    ready = 1'b0;
    idle(1);
    w = front_word();
    check_eq("acc_valid", 32'(obs_valid), 32'd0);
    check_eq("acc_ovr",   32'(obs_ovr),   32'd0);
    check_eq("acc_count", 32'(q.size()),  32'd1);
    check_eq("acc_data",  32'(w.d),       32'h11);

    // Reset in the middle of the data bits, with a word held
    send_bits({6'b0, 1'b1, 8'h77, 1'b0}, 10);
    idle(16);
    check_eq("held_valid", 32'(obs_valid), 32'd1);
    send_bits(16'h0004, 4);
    rst = 1'b1;
    idle(3);
    check_eq("mid_rst_valid", 32'(obs_valid), 32'd0);
    check_eq("mid_rst_data",  32'(obs_data),  32'd0);
    check_eq("mid_rst_fe",    32'(obs_fe),    32'd0);
    check_eq("mid_rst_pe",    32'(obs_pe),    32'd0);
    check_eq("mid_rst_ovr",   32'(obs_ovr),   32'd0);
    check_eq("mid_rst_state", 32'(u_a.state), 32'(ST_IDLE));
    rst = 1'b0;
    ready = 1'b1;
    q.delete();
    idle(40);
    check_eq("post_rst_quiet", 32'(q.size()), 32'd0);
    send_bits({6'b0, 1'b1, 8'h5A, 1'b0}, 10);
    idle(16);
    w = front_word();
    check_eq("5a_data", 32'(w.d),  32'h5A);
    check_eq("5a_fe",   32'(w.fe), 32'd0);
    check_eq("5a_pe",   32'(w.pe), 32'd0);

    // Even parity receiver
    sel = 1;
    idle(20);
    q.delete();
    send_bits({5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
    idle(16);
    send_bits({5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    idle(16);
    check_eq("par_count", 32'(q.size()), 32'd2);
    w = front_word();
    check_eq("par03_data", 32'(w.d),  32'h03);
    check_eq("par03_pe",   32'(w.pe), 32'd1);
    if (q.size() > 0) void'(q.pop_front());
    w = front_word();
    check_eq("par07_data", 32'(w.d),  32'h07);
    check_eq("par07_pe",   32'(w.pe), 32'd0);

    // Two stop bits, second one low, then a clean frame
    sel = 2;
    idle(20);
    q.delete(); brk_cnt = 0;
    send_bits({5'b0, 1'b0, 1'b1, 8'h81, 1'b0}, 11);
    idle(32);
    w = front_word();
    check_eq("stop2_data", 32'(w.d),  32'h81);
    check_eq("stop2_fe",   32'(w.fe), 32'd1);
    check_eq("stop2_brk",  32'(brk_cnt), 32'd0);
    q.delete();
    send_bits({5'b0, 1'b1, 1'b1, 8'h42, 1'b0}, 11);
    idle(16);
    w = front_word();
    check_eq("stop2ok_data", 32'(w.d),  32'h42);
    check_eq("stop2ok_fe",   32'(w.fe), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
